// File: rtl/sprite_rom_arbiter_if.sv
// Fetch-side bus of the sprite ROM arbiter: requester handshake, ROM port and tagged response.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 3
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic                    hold;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_oob;

    modport master (
        output req, addr, hold, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_oob
    );

    modport slave (
        input  req, addr, hold, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_oob
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one sprite ROM; grant same cycle, response 2 cycles after accept, no backpressure.
// Define SPRITE_ARB_BOUNDS_EN to redirect addresses >= DEPTH to 0 and flag them on rsp_oob.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 3,
    parameter int DEPTH  = 5000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sprite_rom_arbiter_if.slave  bus
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   next_ptr;
    logic              found;
    logic              accept;
    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] s2_data;
    logic [ADDR_W-1:0] addr_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.addr[g*ADDR_W +: ADDR_W];
    end

    // Scan from ptr upward; the first asserted request wins.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        cand    = '0;
        bus.gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        accept = found && !bus.hold && rst_n;
        if (accept) begin
            bus.gnt[win] = 1'b1;
        end
    end

    assign next_ptr = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign sel_addr = addr_arr[win];

`ifdef SPRITE_ARB_BOUNDS_EN
    logic oob_in;
    logic s1_oob;

    assign oob_in    = (sel_addr >= ADDR_W'(DEPTH));
    assign next_addr = oob_in ? '0 : sel_addr;
    assign s2_data   = s1_oob ? '0 : bus.rom_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_oob      <= 1'b0;
            bus.rsp_oob <= 1'b0;
        end else begin
            s1_oob      <= accept && oob_in;
            bus.rsp_oob <= s1_valid && s1_oob;
        end
    end
`else
    assign next_addr   = sel_addr;
    assign s2_data     = bus.rom_data;
    assign bus.rsp_oob = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.rom_addr  <= '0;
            s1_valid      <= 1'b0;
            s1_id         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                ptr          <= next_ptr;
                bus.rom_addr <= next_addr;
                s1_id        <= win;
            end
            bus.rsp_valid <= s1_valid;
            bus.rsp_id    <= s1_id;
            // ROM data is only meaningful while stage 1 holds a live fetch.
            if (s1_valid) begin
                bus.rsp_data <= s2_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a combinational ROM model on the ROM port.
module tb_sprite_rom_arbiter;

    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_rom_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(5000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [DATA_W-1:0] mem(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a * 13'd3 + 13'd1;
        return t[DATA_W-1:0];
    endfunction

    assign bus.rom_data = mem(bus.rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        bus.addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    logic [ADDR_W-1:0] exp_ra;
    logic [DATA_W-1:0] exp_rd;
    logic              exp_oob;

    initial begin
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.addr = '0;
        bus.hold = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        chk("rst_rsp_oob", 32'(bus.rsp_oob), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        step();

        // single fetch
        bus.req = 4'b0001;
        set_addr(0, 13'h0012);
        #1;
        chk("one_gnt", 32'(bus.gnt), 32'h1);
        step();
        bus.req = '0;
        #1;
        chk("one_rom_addr", 32'(bus.rom_addr), 32'h12);
        chk("one_early_valid", 32'(bus.rsp_valid), 32'h0);
        step();
        #1;
        chk("one_valid", 32'(bus.rsp_valid), 32'h1);
        chk("one_id", 32'(bus.rsp_id), 32'h0);
        chk("one_data", 32'(bus.rsp_data), 32'(mem(13'h0012)));
        step();
        #1;
        chk("one_pulse_end", 32'(bus.rsp_valid), 32'h0);

        // park pointer at 0 by granting requester 3
        bus.req = 4'b1000;
        #1;
        chk("park_gnt", 32'(bus.gnt), 32'h8);
        step();
        bus.req = '0;
        step();
        step();

        // rotation with all four requesting
        for (int i = 0; i < N_REQ; i++) set_addr(i, ADDR_W'(13'h100 + i));
        bus.req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) bus.req = '0;
            #1;
            if (c < 8) chk("rot_gnt", 32'(bus.gnt), 32'(1 << (c % 4)));
            else       chk("rot_gnt_idle", 32'(bus.gnt), 32'h0);
            if (c >= 2) begin
                chk("rot_valid", 32'(bus.rsp_valid), 32'h1);
                chk("rot_id", 32'(bus.rsp_id), 32'((c - 2) % 4));
                chk("rot_data", 32'(bus.rsp_data), 32'(mem(ADDR_W'(13'h100 + (c - 2) % 4))));
            end
            step();
        end
        #1;
        chk("rot_drained", 32'(bus.rsp_valid), 32'h0);

        // pointer fairness: after granting 1, 1010 goes to 3 then 1
        bus.req = 4'b0010;
        #1;
        chk("fair_g1", 32'(bus.gnt), 32'h2);
        step();
        bus.req = 4'b1010;
        #1;
        chk("fair_g3", 32'(bus.gnt), 32'h8);
        step();
        #1;
        chk("fair_g1b", 32'(bus.gnt), 32'h2);
        chk("fair_rsp0", 32'(bus.rsp_id), 32'h1);
        step();
        bus.req = '0;
        #1;
        chk("fair_rsp1_v", 32'(bus.rsp_valid), 32'h1);
        chk("fair_rsp1", 32'(bus.rsp_id), 32'h3);
        step();
        #1;
        chk("fair_rsp2", 32'(bus.rsp_id), 32'h1);
        step();

        // hold: two accepts, then hold drains both responses with no grants
        bus.req = 4'b0011;
        #1;
        chk("hold_pre_g0", 32'(bus.gnt), 32'h1);
        step();
        #1;
        chk("hold_pre_g1", 32'(bus.gnt), 32'h2);
        step();
        bus.hold = 1'b1;
        #1;
        chk("hold_gnt_a", 32'(bus.gnt), 32'h0);
        chk("hold_rsp_a_v", 32'(bus.rsp_valid), 32'h1);
        chk("hold_rsp_a_id", 32'(bus.rsp_id), 32'h0);
        step();
        #1;
        chk("hold_gnt_b", 32'(bus.gnt), 32'h0);
        chk("hold_rsp_b_v", 32'(bus.rsp_valid), 32'h1);
        chk("hold_rsp_b_id", 32'(bus.rsp_id), 32'h1);
        step();
        #1;
        chk("hold_rsp_end", 32'(bus.rsp_valid), 32'h0);
        bus.hold = 1'b0;
        #1;
        chk("hold_ptr_frozen", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        step();

        // reset mid-flight discards in-flight responses
        bus.req = 4'b1100;
        #1;
        chk("rstf_g2", 32'(bus.gnt), 32'h4);
        step();
        #1;
        chk("rstf_g3", 32'(bus.gnt), 32'h8);
        step();
        bus.req = '0;
        rst_n = 1'b0;
        #1;
        chk("rstf_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rstf_rom_addr", 32'(bus.rom_addr), 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rstf_quiet", 32'(bus.rsp_valid), 32'h0);
            step();
        end

        // bounds: 5000 is just past the last entry, 4999 is the last one
`ifdef SPRITE_ARB_BOUNDS_EN
        exp_ra  = '0;
        exp_rd  = '0;
        exp_oob = 1'b1;
`else
        exp_ra  = 13'd5000;
        exp_rd  = mem(13'd5000);
        exp_oob = 1'b0;
`endif
        set_addr(0, 13'd5000);
        bus.req = 4'b0001;
        #1;
        chk("oob_gnt", 32'(bus.gnt), 32'h1);
        step();
        bus.req = '0;
        #1;
        chk("oob_rom_addr", 32'(bus.rom_addr), 32'(exp_ra));
        step();
        #1;
        chk("oob_valid", 32'(bus.rsp_valid), 32'h1);
        chk("oob_data", 32'(bus.rsp_data), 32'(exp_rd));
        chk("oob_flag", 32'(bus.rsp_oob), 32'(exp_oob));
        step();

        set_addr(0, 13'd4999);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        #1;
        chk("last_rom_addr", 32'(bus.rom_addr), 32'd4999);
        step();
        #1;
        chk("last_valid", 32'(bus.rsp_valid), 32'h1);
        chk("last_data", 32'(bus.rsp_data), 32'(mem(13'd4999)));
        chk("last_flag", 32'(bus.rsp_oob), 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
